// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared register-file widths, constants and dump FSM encodings
//
// Purpose : common definitions for the register-file dump engine and the
//           core top level that muxes the register-file read port.
// Contents: RegBus / RegAddrBus data and address types, RegNum, ZeroWord,
//           RstEnable, ReadEnable, the dump FSM state encodings and a
//           helper that recognises the final register index.

package regfile_dump_pkg;

    localparam int RegBusW  = 32;
    localparam int RegAddrW = 5;
    localparam int RegNum   = 32;

    typedef logic [RegBusW-1:0]  RegBus;
    typedef logic [RegAddrW-1:0] RegAddrBus;

    localparam RegBus     ZeroWord   = '0;
    localparam RegAddrBus ZeroAddr   = '0;
    localparam RegAddrBus LastIdx    = RegAddrBus'(RegNum - 1);
    localparam logic      RstEnable  = 1'b1;
    localparam logic      ReadEnable = 1'b1;

    typedef enum logic [1:0] {
        DumpIdle = 2'd0,
        DumpRead = 2'd1,
        DumpHold = 2'd2,
        DumpDone = 2'd3
    } dump_state_e;

    // True when idx addresses the highest register; the dump ends there
    // instead of incrementing, so idx never wraps inside a dump.
    function automatic logic is_last_idx(input RegAddrBus idx);
        return idx == LastIdx;
    endfunction

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks all 32 registers out of the register-file read port as a ready/valid stream
//
// Purpose : on start, freezes the pipeline and reads registers 0..31 one at a
//           time, presenting each as a dump word with a running XOR checksum.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           start, abort    - begin a dump / abandon the dump in progress
//           re, raddr       - register-file read port request (READ only)
//           rdata           - combinational register-file read data
//           stall_req       - pipeline freeze, high in READ and HOLD
//           dump_valid      - dump word present (HOLD only)
//           dump_ready      - consumer accepts the dump word
//           dump_addr/data  - register index and captured value
//           done            - one-cycle pulse at the end of a complete dump
//           checksum        - XOR of the dumped words
//
// Every output is a register, updated in the same edge as the state change
// it belongs to, so the read-port request and the pipeline freeze never
// glitch and align exactly with the state.

module regfile_dump
    import regfile_dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                re,
    output logic [RegAddrW-1:0] raddr,
    input  logic [RegBusW-1:0]  rdata,
    output logic                stall_req,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [RegAddrW-1:0] dump_addr,
    output logic [RegBusW-1:0]  dump_data,
    output logic                done,
    output logic [RegBusW-1:0]  checksum
);

    dump_state_e state_q;
    RegAddrBus   idx_q;
    logic        re_q;
    RegAddrBus   raddr_q;
    logic        stall_q;
    logic        valid_q;
    RegAddrBus   dump_addr_q;
    RegBus       dump_data_q;
    logic        done_q;
    RegBus       checksum_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= DumpIdle;
            idx_q       <= ZeroAddr;
            re_q        <= 1'b0;
            raddr_q     <= ZeroAddr;
            stall_q     <= 1'b0;
            valid_q     <= 1'b0;
            dump_addr_q <= ZeroAddr;
            dump_data_q <= ZeroWord;
            done_q      <= 1'b0;
            checksum_q  <= ZeroWord;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DumpIdle: begin
                    // abort outranks start so a stray abort cannot be
                    // overridden by a coincident request.
                    if (start && !abort) begin
                        state_q    <= DumpRead;
                        idx_q      <= ZeroAddr;
                        checksum_q <= ZeroWord;
                        re_q       <= ReadEnable;
                        raddr_q    <= ZeroAddr;
                        stall_q    <= 1'b1;
                    end
                end

                DumpRead: begin
                    re_q    <= 1'b0;
                    raddr_q <= ZeroAddr;
                    if (abort) begin
                        state_q <= DumpIdle;
                        stall_q <= 1'b0;
                    end else begin
                        // Register 0 needs no special case: the register
                        // file already returns zero for it.
                        state_q     <= DumpHold;
                        dump_data_q <= rdata;
                        dump_addr_q <= idx_q;
                        checksum_q  <= checksum_q ^ rdata;
                        valid_q     <= 1'b1;
                    end
                end

                DumpHold: begin
                    if (abort) begin
                        state_q <= DumpIdle;
                        valid_q <= 1'b0;
                        stall_q <= 1'b0;
                    end else if (dump_ready) begin
                        valid_q <= 1'b0;
                        if (is_last_idx(idx_q)) begin
                            state_q <= DumpDone;
                            stall_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DumpRead;
                            idx_q   <= idx_q + RegAddrBus'(1);
                            re_q    <= ReadEnable;
                            raddr_q <= idx_q + RegAddrBus'(1);
                        end
                    end
                end

                DumpDone: begin
                    // done is already high for this single cycle; abort
                    // here lands in IDLE just the same.
                    state_q <= DumpIdle;
                end

                default: begin
                    state_q <= DumpIdle;
                    re_q    <= 1'b0;
                    raddr_q <= ZeroAddr;
                    stall_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign re         = re_q;
    assign raddr      = raddr_q;
    assign stall_req  = stall_q;
    assign dump_valid = valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign done       = done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump with a modelled register file

module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        re;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        stall_req;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        done;
    logic [31:0] checksum;

    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rf [32];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_rf [32];
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .re         (re),
        .raddr      (raddr),
        .rdata      (rdata),
        .stall_req  (stall_req),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .done       (done),
        .checksum   (checksum)
    );

    // Register file with r0 hard-wired to zero and same-cycle write-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == 5'd0) ? 32'h0 :
                   (we && waddr == raddr) ? wdata : rf[raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dump_valid && dump_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {27'h0, dump_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("word_addr", {27'h0, dump_addr}, {27'h0, e.addr});
                    check("word_data", dump_data, e.data);
                end
            end
        end
    endtask

    task automatic push_dump();
        for (int k = 0; k < 32; k++) sb.push_back({5'(k), exp_rf[k]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hold(input logic [4:0] a);
        int n = 0;
        while (!(dump_valid && dump_addr == a) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("timeout_hold", 32'(n), 32'd0);
    endtask

    task automatic wait_read(input logic [4:0] a);
        int n = 0;
        while (!(re && raddr == a) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("timeout_read", 32'(n), 32'd0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        if (cycles >= 200) check("timeout_done", 32'(cycles), 32'd0);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_re"}, {31'h0, re}, 32'h0);
        check({tag, "_raddr"}, {27'h0, raddr}, 32'h0);
        check({tag, "_stall"}, {31'h0, stall_req}, 32'h0);
        check({tag, "_valid"}, {31'h0, dump_valid}, 32'h0);
        check({tag, "_addr"}, {27'h0, dump_addr}, 32'h0);
        check({tag, "_data"}, dump_data, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_csum"}, checksum, 32'h0);
    endtask

    initial begin
        int cyc;
        int dc;
        fork
            monitor();
        join_none

        // Reset state
        tick();
        tick();
        outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Preload reg k = 0x1000_0000 + k through the write port
        exp_rf[0] = 32'h0;
        we = 1'b1;
        for (int k = 1; k < 32; k++) begin
            waddr = 5'(k);
            wdata = 32'h1000_0000 + 32'(k);
            exp_rf[k] = wdata;
            tick();
        end
        we = 1'b0;
        tick();

        // Full dump with ready held high, latency and checksum
        dump_ready = 1'b1;
        push_dump();
        pulse_start();
        check("first_read_re", {31'h0, re}, 32'h1);
        check("first_read_addr", {27'h0, raddr}, 32'h0);
        check("first_read_stall", {31'h0, stall_req}, 32'h1);
        tick();
        check("first_hold_valid", {31'h0, dump_valid}, 32'h1);
        check("first_hold_re", {31'h0, re}, 32'h0);
        check("reg0_data", dump_data, 32'h0);
        wait_done(cyc);
        // done rises at the 64th edge after the start edge, i.e. it is high
        // during the 65th cycle counted from the start edge.
        check("done_latency", 32'(cyc + 1), 32'd64);
        // 31 copies of 0x1000_0000 XOR to 0x1000_0000; 1..31 XOR to 0.
        check("checksum_full", checksum, 32'h1000_0000);
        check("done_stall", {31'h0, stall_req}, 32'h0);
        tick();
        check("done_one_cycle", {31'h0, done}, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("checksum_stable", checksum, 32'h1000_0000);
        check("sb_empty_full", 32'(sb.size()), 32'd0);
        check("done_count_1", 32'(done_cnt), 32'd1);

        // Back-pressure at word 7
        push_dump();
        pulse_start();
        wait_hold(5'd7);
        dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'h0, dump_valid}, 32'h1);
            check("bp_data", dump_data, 32'h1000_0007);
            check("bp_addr", {27'h0, dump_addr}, 32'd7);
        end
        dump_ready = 1'b1;
        tick();
        check("bp_resume_valid", {31'h0, dump_valid}, 32'h0);
        check("bp_resume_re", {31'h0, re}, 32'h1);
        check("bp_resume_raddr", {27'h0, raddr}, 32'd8);
        wait_done(cyc);
        tick();
        check("done_count_2", 32'(done_cnt), 32'd2);
        check("sb_empty_bp", 32'(sb.size()), 32'd0);

        // Abort in HOLD of word 12
        push_dump();
        pulse_start();
        wait_hold(5'd12);
        dump_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        check("abort_valid", {31'h0, dump_valid}, 32'h0);
        check("abort_stall", {31'h0, stall_req}, 32'h0);
        check("abort_re", {31'h0, re}, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("abort_idle_stall", {31'h0, stall_req}, 32'h0);
        check("abort_no_done", 32'(done_cnt), 32'd2);
        dump_ready = 1'b1;
        push_dump();
        pulse_start();
        check("restart_raddr", {27'h0, raddr}, 32'd0);
        wait_done(cyc);
        tick();
        check("done_count_3", 32'(done_cnt), 32'd3);
        check("sb_empty_restart", 32'(sb.size()), 32'd0);

        // Reset in READ of word 20, with start asserted during reset
        push_dump();
        pulse_start();
        wait_read(5'd20);
        rst = 1'b1;
        start = 1'b1;
        tick();
        outputs_zero("midreset");
        rst = 1'b0;
        start = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) tick();
        check("post_reset_stall", {31'h0, stall_req}, 32'h0);
        check("post_reset_re", {31'h0, re}, 32'h0);
        check("post_reset_no_done", 32'(done_cnt), 32'd3);

        // Reset cleared the modelled register file; reload it
        we = 1'b1;
        for (int k = 1; k < 32; k++) begin
            waddr = 5'(k);
            wdata = 32'h1000_0000 + 32'(k);
            tick();
        end
        we = 1'b0;
        tick();

        // Write reg 5 in the same cycle as its READ
        exp_rf[5] = 32'hDEAD_BEEF;
        push_dump();
        pulse_start();
        wait_read(5'd5);
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0;
        check("wt_data", dump_data, 32'hDEAD_BEEF);
        wait_done(cyc);
        // 0x1000_0000 ^ 0x1000_0005 ^ 0xDEAD_BEEF
        check("wt_checksum", checksum, 32'hDEAD_BEEA);
        tick();
        check("done_count_4", 32'(done_cnt), 32'd4);

        // start while running (HOLD of word 3) is ignored
        push_dump();
        pulse_start();
        wait_hold(5'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = done_cnt;
        wait_done(cyc);
        for (int i = 0; i < 6; i++) tick();
        check("restart_single_done", 32'(done_cnt - dc), 32'd1);
        check("restart_stall", {31'h0, stall_req}, 32'h0);
        check("restart_checksum", checksum, 32'hDEAD_BEEA);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
